// File: rtl/buf_pkg.sv
// Shared types and encodings for the byte-serializing buffer sequencer.
// Used by buf_seq_ctrl and its optional watchdog (BUF_SEQ_CTRL_TIMEOUT_EN).
package buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_LAST    = 3'd4,
    ST_STREAM  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Host command codes; 2'b00 and 2'b10 are no-ops.
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [1:0] BUFCMD_IDLE = 2'b00;
  localparam logic [1:0] BUFCMD_LOAD = 2'b01;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ABORT    = 2'b11;

  function automatic logic is_cmd(input logic fire, input logic [1:0] cmd,
                                  input logic [1:0] code);
    return fire && (cmd == code);
  endfunction

endpackage

// File: rtl/seq_wdog.sv
// Idle watchdog for the STREAM phase: expire fires on the idle cycle that makes the
// gap from the last byte to done equal to TIMEOUT cycles. Used with BUF_SEQ_CTRL_TIMEOUT_EN.
module seq_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter value seen on the idle cycle just before done: byte cycle + (TIMEOUT-1) idle cycles.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = tick && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/buf_seq_ctrl.sv
// Sequencer for the WORDS x 32 byte-serializing buffer: loads a host frame, closes it,
// counts the streamed bytes and reports status. BUF_SEQ_CTRL_TIMEOUT_EN adds a STREAM watchdog.
module buf_seq_ctrl
  import buf_pkg::*;
#(
  parameter int WORDS   = 512,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd,
  output logic                   cmd_ready,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   buf_data_ready,
  output logic [1:0]             buf_command,
  output logic                   buf_last,
  output logic                   buf_rst_n,
  input  logic                   byte_val,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err_code,
  output logic [$clog2(WORDS):0] loaded_words
);

  localparam int LW = $clog2(WORDS) + 1;
  localparam int BW = $clog2(WORDS * 4) + 1;
  localparam logic [LW-1:0] WORDS_MAX = LW'(WORDS);
  localparam logic [BW-1:0] BYTES_MAX = BW'(WORDS * 4);

  state_e        state_q, state_d;
  logic [LW-1:0] loaded_q, loaded_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]    err_q, err_d;
  logic          buf_rst_n_q, buf_rst_n_d;

  logic cmd_fire, load_cmd, abort_cmd, beat, wdog_expire;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign load_cmd  = is_cmd(cmd_fire, cmd, CMD_LOAD);
  assign abort_cmd = is_cmd(cmd_fire, cmd, CMD_ABORT);
  assign beat      = s_valid && s_ready;

`ifdef BUF_SEQ_CTRL_TIMEOUT_EN
  seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state_q != ST_STREAM) || byte_val),
    .tick   ((state_q == ST_STREAM) && !byte_val),
    .expire (wdog_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT, ERR_TIMEOUT};
  assign wdog_expire    = 1'b0;
`endif

  // Next-state and counter updates; buf_rst_n_d low marks the cycles that re-arm the buffer.
  always_comb begin
    state_d     = state_q;
    loaded_d    = loaded_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    buf_rst_n_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (load_cmd) begin
          state_d     = ST_CLR;
          loaded_d    = '0;
          byte_cnt_d  = '0;
          err_d       = ERR_OK;
          buf_rst_n_d = 1'b0;
        end
      end

      ST_CLR: state_d = ST_LOAD;

      ST_LOAD: begin
        if (abort_cmd) begin
          state_d     = ST_DONE;
          err_d       = ERR_ABORT;
          buf_rst_n_d = 1'b0;
        end else if (beat) begin
          if (loaded_q != WORDS_MAX) begin
            loaded_d = loaded_q + 1'b1;
          end
          if (s_last) begin
            state_d = ST_LAST;
          end else if (loaded_q == WORDS_MAX - 1'b1) begin
            state_d = ST_DISCARD;
            err_d   = ERR_OVERFLOW;
          end
        end
      end

      ST_DISCARD: begin
        if (abort_cmd) begin
          state_d     = ST_DONE;
          err_d       = ERR_ABORT;
          buf_rst_n_d = 1'b0;
        end else if (beat && s_last) begin
          state_d = ST_LAST;
        end
      end

      ST_LAST: state_d = ST_STREAM;

      ST_STREAM: begin
        if (byte_val) begin
          if (byte_cnt_q != BYTES_MAX) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
          if (byte_cnt_q == BYTES_MAX - 1'b1) begin
            state_d = ST_DONE;
          end
        end else if (wdog_expire) begin
          state_d     = ST_DONE;
          err_d       = ERR_TIMEOUT;
          buf_rst_n_d = 1'b0;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values;
  // the reset is synchronous to match the rest of the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      loaded_q    <= '0;
      byte_cnt_q  <= '0;
      err_q       <= ERR_OK;
      buf_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      loaded_q    <= loaded_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      buf_rst_n_q <= buf_rst_n_d;
    end
  end

  // Moore output decode. In IDLE, buf_rst_n_q is low only while reset is held,
  // so it doubles as the "out of reset" qualifier for cmd_ready.
  always_comb begin
    cmd_ready      = 1'b0;
    s_ready        = 1'b0;
    buf_data_ready = 1'b0;
    buf_command    = BUFCMD_IDLE;
    buf_last       = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      ST_IDLE: cmd_ready = buf_rst_n_q;
      ST_LOAD: begin
        cmd_ready      = 1'b1;
        s_ready        = 1'b1;
        buf_data_ready = 1'b1;
        buf_command    = BUFCMD_LOAD;
      end
      ST_DISCARD: begin
        cmd_ready   = 1'b1;
        s_ready     = 1'b1;
        buf_command = BUFCMD_LOAD;
      end
      ST_LAST: begin
        buf_last    = 1'b1;
        buf_command = BUFCMD_LOAD;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign buf_rst_n    = buf_rst_n_q;
  assign err_code     = err_q;
  assign loaded_words = loaded_q;

endmodule

// File: tb/tb_buf_seq_ctrl.sv
// Self-checking bench for buf_seq_ctrl: table-driven frames, randomized frames against a
// frame-outcome model, and hand sequences for reset, idle commands and STREAM stalls.
module tb_buf_seq_ctrl;
  import buf_pkg::*;

  localparam int WORDS   = 512;
  localparam int TIMEOUT = 64;
  localparam int NBYTES  = WORDS * 4;
  localparam int LW      = $clog2(WORDS) + 1;

  logic          clk = 1'b0;
  logic          rst_n, cmd_valid, s_valid, s_last, byte_val;
  logic [1:0]    cmd;
  logic          cmd_ready, s_ready, buf_data_ready, buf_last, buf_rst_n, busy, done;
  logic [1:0]    buf_command, err_code;
  logic [LW-1:0] loaded_words;

  int         n_cmp = 0;
  int         n_bad = 0;
  string      tag = "";
  int         last_words = 0;
  logic [1:0] last_err = 2'b00;

  typedef struct {
    int         beats;
    int         abort_at;    // ABORT issued after this many beats; -1 = none
    bit         gaps;        // random idle cycles plus harmless command noise
    bit         abort_last;  // ABORT cycle also carries an s_last beat
    int         stall_at;    // STREAM stall after this many bytes; 0 = none
    int         exp_words;
    logic [1:0] exp_err;
  } vec_t;

  always #5 clk = ~clk;

  buf_seq_ctrl #(
    .WORDS   (WORDS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd            (cmd),
    .cmd_ready      (cmd_ready),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .buf_data_ready (buf_data_ready),
    .buf_command    (buf_command),
    .buf_last       (buf_last),
    .buf_rst_n      (buf_rst_n),
    .byte_val       (byte_val),
    .busy           (busy),
    .done           (done),
    .err_code       (err_code),
    .loaded_words   (loaded_words)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got 0x%0h, want 0x%0h", tag, name, got, exp);
    end
  endtask

  // Frame outcome from the host's point of view: what reached the buffer and why it ended.
  function automatic void ref_outcome(input int beats, input int abort_at,
                                      output int words, output logic [1:0] err);
    if (abort_at >= 0) begin
      words = (abort_at < WORDS) ? abort_at : WORDS;
      err   = ERR_ABORT;
    end else begin
      words = (beats < WORDS) ? beats : WORDS;
      err   = (beats > WORDS) ? ERR_OVERFLOW : ERR_OK;
    end
  endfunction

  task automatic clear_inputs();
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    byte_val  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int bad_hs;
    bit early;
    bit aborted;
    int cyc;
    bad_hs  = 0;
    early   = 1'b0;
    aborted = 1'b0;

    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd       = CMD_LOAD;
    @(negedge clk);
    clear_inputs();
    check("clr_buf_rst_n", buf_rst_n, 0);
    check("clr_s_ready", s_ready, 0);
    @(negedge clk);
    check("load_s_ready", s_ready, 1);
    check("load_words_cleared", loaded_words, 0);
    check("load_err_cleared", err_code, ERR_OK);

    for (int i = 1; i <= v.beats; i++) begin
      clear_inputs();
      if (v.gaps && $urandom_range(7) == 0) begin
        cmd_valid = 1'($urandom_range(1));
        cmd       = 2'($urandom_range(2));
        @(negedge clk);
        clear_inputs();
      end
      if (s_ready !== 1'b1 || cmd_ready !== 1'b1 || buf_last !== 1'b0 ||
          buf_data_ready !== (i <= WORDS) || buf_rst_n !== 1'b1)
        bad_hs++;
      if (v.abort_at >= 0 && i == v.abort_at + 1) begin
        cmd_valid = 1'b1;
        cmd       = CMD_ABORT;
        s_valid   = v.abort_last;
        s_last    = v.abort_last;
        aborted   = 1'b1;
        @(negedge clk);
        clear_inputs();
        break;
      end
      s_valid = 1'b1;
      s_last  = (i == v.beats);
      if (v.gaps) begin
        cmd_valid = 1'($urandom_range(1));
        cmd       = 2'($urandom_range(2));
      end
      @(negedge clk);
    end
    clear_inputs();
    check("beat_handshake_errors", bad_hs, 0);

    if (aborted) begin
      check("abort_done", done, 1);
      check("abort_buf_rst_n", buf_rst_n, 0);
      check("abort_err", err_code, v.exp_err);
      check("abort_words", loaded_words, v.exp_words);
      @(negedge clk);
      check("abort_idle", busy, 0);
      check("abort_done_one_cycle", done, 0);
      check("abort_rst_release", buf_rst_n, 1);
      last_words = v.exp_words;
      last_err   = v.exp_err;
      return;
    end

    check("last_pulse", buf_last, 1);
    check("last_no_write", buf_data_ready, 0);
    check("last_s_ready", s_ready, 0);
    check("last_bufcmd", buf_command, BUFCMD_LOAD);
    check("last_words", loaded_words, v.exp_words);
    @(negedge clk);
    check("stream_last_one_cycle", buf_last, 0);
    check("stream_bufcmd", buf_command, BUFCMD_IDLE);
    check("stream_cmd_ready", cmd_ready, 0);

    for (int k = 1; k <= NBYTES; k++) begin
      if (v.stall_at > 0 && k == v.stall_at + 1) begin
        byte_val = 1'b0;
`ifdef BUF_SEQ_CTRL_TIMEOUT_EN
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
          @(negedge clk);
          cyc++;
        end
        check("timeout_latency", cyc, TIMEOUT);
        check("timeout_err", err_code, ERR_TIMEOUT);
        check("timeout_buf_rst_n", buf_rst_n, 0);
        check("timeout_words", loaded_words, v.exp_words);
        @(negedge clk);
        check("timeout_idle", busy, 0);
        check("timeout_rst_release", buf_rst_n, 1);
        last_words = v.exp_words;
        last_err   = ERR_TIMEOUT;
        return;
`else
        cyc = 0;
        repeat (200) begin
          @(negedge clk);
          if (done === 1'b1) early = 1'b1;
          cyc++;
        end
        check("stall_still_busy", busy, 1);
`endif
      end
      if (v.gaps && $urandom_range(7) == 0) begin
        byte_val = 1'b0;
        @(negedge clk);
        if (done === 1'b1) early = 1'b1;
      end
      byte_val = 1'b1;
      @(negedge clk);
      byte_val = 1'b0;
      if (k < NBYTES && done === 1'b1) early = 1'b1;
    end

    check("no_early_done", early, 0);
    check("done_latency", done, 1);
    check("done_err", err_code, v.exp_err);
    check("done_words", loaded_words, v.exp_words);
    check("done_buf_rst_n", buf_rst_n, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("back_to_idle", busy, 0);
    check("err_held", err_code, v.exp_err);
    last_words = v.exp_words;
    last_err   = v.exp_err;
  endtask

  initial begin
    vec_t vecs[8];
    vec_t rv;

    vecs[0] = '{512, -1, 1'b0, 1'b0, 0,   512, ERR_OK};        // full frame, s_last on beat WORDS
    vecs[1] = '{10,  -1, 1'b1, 1'b0, 0,   10,  ERR_OK};        // short frame
    vecs[2] = '{520, -1, 1'b0, 1'b0, 0,   512, ERR_OVERFLOW};  // overflow
    vecs[3] = '{6,   5,  1'b0, 1'b1, 0,   5,   ERR_ABORT};     // ABORT beats a simultaneous s_last
    vecs[4] = '{33,  -1, 1'b1, 1'b0, 0,   33,  ERR_OK};        // normal frame after abort
    vecs[5] = '{513, -1, 1'b0, 1'b0, 0,   512, ERR_OVERFLOW};  // s_last lands in DISCARD
    vecs[6] = '{530, 515, 1'b0, 1'b0, 0,  512, ERR_ABORT};     // ABORT during DISCARD
    vecs[7] = '{40,  -1, 1'b0, 1'b0, 100, 40,  ERR_OK};        // STREAM stall after 100 bytes

    clear_inputs();
    rst_n = 1'b0;

    tag = "reset";
    repeat (3) @(negedge clk);
    check("busy", busy, 0);
    check("done", done, 0);
    check("cmd_ready", cmd_ready, 0);
    check("s_ready", s_ready, 0);
    check("buf_data_ready", buf_data_ready, 0);
    check("buf_command", buf_command, 0);
    check("buf_last", buf_last, 0);
    check("buf_rst_n", buf_rst_n, 0);
    check("err_code", err_code, 0);
    check("loaded_words", loaded_words, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("buf_rst_n_release", buf_rst_n, 1);
    check("idle_after_release", busy, 0);
    check("cmd_ready_after_release", cmd_ready, 1);

    for (int t = 0; t < 8; t++) begin
      tag = $sformatf("vec%0d", t);
      run_frame(vecs[t]);
    end

    tag = "idle_cmds";
    @(negedge clk);
    check("abort_accepted", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd       = CMD_ABORT;
    @(negedge clk);
    cmd = 2'b10;
    check("abort_no_effect_busy", busy, 0);
    check("abort_no_effect_err", err_code, last_err);
    @(negedge clk);
    clear_inputs();
    check("noop_no_effect_busy", busy, 0);
    check("noop_no_effect_words", loaded_words, last_words);

    for (int r = 0; r < 6; r++) begin
      rv.beats      = $urandom_range(600, 1);
      rv.abort_at   = ($urandom_range(3) == 0) ? $urandom_range(rv.beats - 1, 0) : -1;
      rv.gaps       = 1'($urandom_range(1));
      rv.abort_last = 1'($urandom_range(1));
      rv.stall_at   = 0;
      ref_outcome(rv.beats, rv.abort_at, rv.exp_words, rv.exp_err);
      tag = $sformatf("rand%0d_b%0d_a%0d", r, rv.beats, rv.abort_at);
      run_frame(rv);
    end

    tag = "mid_reset";
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = CMD_LOAD;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check("busy", busy, 0);
    check("buf_rst_n", buf_rst_n, 0);
    check("loaded_words", loaded_words, 0);
    check("s_ready", s_ready, 0);
    @(negedge clk);
    check("buf_rst_n_held", buf_rst_n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("buf_rst_n_release", buf_rst_n, 1);
    check("cmd_ready", cmd_ready, 1);

    tag = "post_reset_frame";
    rv = '{7, -1, 1'b0, 1'b0, 0, 0, ERR_OK};
    ref_outcome(rv.beats, rv.abort_at, rv.exp_words, rv.exp_err);
    run_frame(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
